// File: rtl/lane_permute_pipe.sv
// Lane permutation stage with ready/valid flow control.
// Incoming words are split into lanes and reordered at push time by a loadable
// map, a self-advancing rotation or a fixed reversal. The reordered words are
// queued in a small first-word-fall-through FIFO.
module lane_permute_pipe #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4,
    parameter int DEPTH  = 2
) (
    input  logic                                clk,
    input  logic                                arst,
    input  logic [LANES*LANE_W-1:0]             in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [1:0]                          mode,
    input  logic [LANES*$clog2(LANES)-1:0]      map_data,
    input  logic                                map_load,
    output logic [LANES*LANE_W-1:0]             out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$clog2(DEPTH):0]              count
);

    localparam int SEL_W  = $clog2(LANES);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = LANES * LANE_W;
    localparam int MAP_W  = LANES * SEL_W;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Field i of the identity map selects source lane i.
    function automatic logic [MAP_W-1:0] identityMap();
        logic [MAP_W-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[i*SEL_W +: SEL_W] = SEL_W'(i);
        end
        return m;
    endfunction

    localparam logic [MAP_W-1:0] MAP_IDENTITY = identityMap();

    logic [SEL_W-1:0]  rot_q, rot_d;
    logic [MAP_W-1:0]  map_q, map_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WORD_W-1:0] mem_q [DEPTH];

    logic [LANE_W-1:0] inLane [LANES];
    logic [WORD_W-1:0] permWord;
    logic              push;
    logic              pop;

    // Split the input word into lanes and build the reordered word for the current mode.
    always_comb begin
        logic [SEL_W-1:0] sel;
        permWord = '0;
        sel      = '0;
        for (int i = 0; i < LANES; i++) begin
            inLane[i] = in_data[i*LANE_W +: LANE_W];
        end
        for (int i = 0; i < LANES; i++) begin
            case (mode)
                2'b01:   sel = SEL_W'(i) + rot_q;
                2'b10:   sel = SEL_W'(LANES - 1 - i);
                default: sel = map_q[i*SEL_W +: SEL_W];
            endcase
            permWord[i*LANE_W +: LANE_W] = inLane[sel];
        end
    end

    // Handshake decode and next-state for occupancy, pointers, rotation and map.
    always_comb begin
        in_ready  = (count_q < FULL_COUNT) & ~arst;
        out_valid = (count_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        out_data  = out_valid ? mem_q[rptr_q] : '0;
        count     = count_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;

        rot_d = rot_q;
        if (map_load) begin
            rot_d = '0;
        end else if (push && (mode == 2'b01)) begin
            rot_d = rot_q + SEL_W'(1);
        end

        map_d = map_load ? map_data : map_q;
    end

    // Control state register; reset empties the FIFO and restores identity map.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            rot_q   <= '0;
            map_q   <= MAP_IDENTITY;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rot_q   <= rot_d;
            map_q   <= map_d;
        end
    end

    // FIFO storage holds already-permuted words; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= permWord;
        end
    end

endmodule

// File: tb/tb_lane_permute_pipe.sv
// Self-checking bench for lane_permute_pipe: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_lane_permute_pipe;

    localparam int LW = 4;
    localparam int NL = 4;
    localparam int DP = 2;
    localparam int SW = 2;

    logic        clk = 1'b0;
    logic        arst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic [7:0]  map_data;
    logic        map_load;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  count;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] expQ [$];
    int          mRot;
    int          mMap [NL];

    lane_permute_pipe #(.LANE_W(LW), .LANES(NL), .DEPTH(DP)) dut (
        .clk       (clk),
        .arst      (arst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .map_data  (map_data),
        .map_load  (map_load),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference permutation: output lane i takes the input lane chosen by the mode rule.
    function automatic logic [15:0] modelPermute(logic [15:0] d, logic [1:0] m);
        logic [15:0] r;
        int          src;
        r = '0;
        for (int i = 0; i < NL; i++) begin
            if (m == 2'b01)      src = (i + mRot) % NL;
            else if (m == 2'b10) src = NL - 1 - i;
            else                 src = mMap[i];
            r[i*LW +: LW] = d[src*LW +: LW];
        end
        return r;
    endfunction

    task automatic modelReset();
        expQ.delete();
        mRot = 0;
        for (int i = 0; i < NL; i++) mMap[i] = i;
    endtask

    task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(string tag);
        logic [15:0] expData;
        expData = (expQ.size() > 0) ? expQ[0] : 16'h0000;
        checkVal({tag, ".count"},     32'(count),     32'(expQ.size()));
        checkVal({tag, ".out_valid"}, 32'(out_valid), 32'(expQ.size() != 0));
        checkVal({tag, ".in_ready"},  32'(in_ready),  32'(expQ.size() < DP));
        checkVal({tag, ".out_data"},  32'(out_data),  32'(expData));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic applyStimulus(input logic iv, input logic [15:0] d, input logic [1:0] m,
                                 input logic ml, input logic [7:0] md, input logic ordy,
                                 input string tag);
        bit          doPush;
        bit          doPop;
        logic [15:0] pw;
        in_valid  = iv;
        in_data   = d;
        mode      = m;
        map_load  = ml;
        map_data  = md;
        out_ready = ordy;
        doPush = iv && (expQ.size() < DP);
        doPop  = ordy && (expQ.size() > 0);
        pw     = modelPermute(d, m);
        @(posedge clk);
        if (doPop) void'(expQ.pop_front());
        if (doPush) expQ.push_back(pw);
        if (ml) begin
            mRot = 0;
            for (int i = 0; i < NL; i++) mMap[i] = int'(md[i*SW +: SW]);
        end else if (doPush && m == 2'b01) begin
            mRot = (mRot + 1) % NL;
        end
        @(negedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic checkResetState(string tag);
        checkVal({tag, ".rst_count"},     32'(count),     32'd0);
        checkVal({tag, ".rst_out_valid"}, 32'(out_valid), 32'd0);
        checkVal({tag, ".rst_in_ready"},  32'(in_ready),  32'd0);
        checkVal({tag, ".rst_out_data"},  32'(out_data),  32'd0);
    endtask

    initial begin
        arst      = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        mode      = 2'b00;
        map_data  = '0;
        map_load  = 1'b0;
        out_ready = 1'b0;
        modelReset();
        #2;
        checkResetState("por");
        @(negedge clk);
        arst = 1'b0;
        #1;
        checkOutput("post_reset");

        $display("[TB] identity after reset");
        applyStimulus(1, 16'h1234, 2'b00, 0, 8'h00, 1, "id_push");
        checkVal("id_word", 32'(out_data), 32'h1234);
        applyStimulus(0, 16'h0000, 2'b00, 0, 8'h00, 1, "id_drain");

        $display("[TB] map load");
        applyStimulus(1, 16'h1234, 2'b00, 1, 8'b00_01_10_11, 1, "map_same_cycle");
        checkVal("map_same_cycle_word", 32'(out_data), 32'h1234);
        applyStimulus(1, 16'h1234, 2'b00, 0, 8'h00, 1, "map_after");
        checkVal("map_after_word", 32'(out_data), 32'h4321);
        applyStimulus(0, 16'h0000, 2'b00, 1, 8'b11_10_01_00, 1, "map_restore");

        $display("[TB] rotate and reverse");
        applyStimulus(1, 16'h1234, 2'b01, 0, 8'h00, 1, "rot0");
        checkVal("rot0_word", 32'(out_data), 32'h1234);
        applyStimulus(1, 16'h1234, 2'b01, 0, 8'h00, 1, "rot1");
        checkVal("rot1_word", 32'(out_data), 32'h4123);
        applyStimulus(1, 16'h1234, 2'b01, 0, 8'h00, 1, "rot2");
        checkVal("rot2_word", 32'(out_data), 32'h3412);
        applyStimulus(1, 16'h1234, 2'b01, 0, 8'h00, 1, "rot3");
        checkVal("rot3_word", 32'(out_data), 32'h2341);
        applyStimulus(1, 16'h1234, 2'b01, 0, 8'h00, 1, "rot4");
        checkVal("rot4_word", 32'(out_data), 32'h1234);
        applyStimulus(1, 16'hABCD, 2'b10, 0, 8'h00, 1, "rev");
        checkVal("rev_word", 32'(out_data), 32'hDCBA);
        applyStimulus(0, 16'h0000, 2'b00, 0, 8'h00, 1, "rev_drain");

        $display("[TB] back-pressure");
        applyStimulus(1, 16'h1111, 2'b00, 0, 8'h00, 0, "bp_a");
        applyStimulus(1, 16'h2222, 2'b00, 0, 8'h00, 0, "bp_b");
        checkVal("bp_full_ready", 32'(in_ready), 32'd0);
        applyStimulus(1, 16'h3333, 2'b00, 0, 8'h00, 0, "bp_c_held");
        checkVal("bp_head_a", 32'(out_data), 32'h1111);
        applyStimulus(1, 16'h3333, 2'b00, 0, 8'h00, 1, "bp_pop_a");
        checkVal("bp_head_b", 32'(out_data), 32'h2222);
        checkVal("bp_ready_back", 32'(in_ready), 32'd1);
        applyStimulus(1, 16'h3333, 2'b00, 0, 8'h00, 1, "bp_pop_b");
        checkVal("bp_head_c", 32'(out_data), 32'h3333);
        applyStimulus(0, 16'h0000, 2'b00, 0, 8'h00, 1, "bp_drain");

        $display("[TB] streaming");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 16'($urandom), 2'b00, 0, 8'h00, 1, "stream");
            checkVal("stream_count", 32'(count), 32'd1);
        end
        applyStimulus(0, 16'h0000, 2'b00, 0, 8'h00, 1, "stream_drain");

        $display("[TB] reset mid-stream");
        applyStimulus(0, 16'h0000, 2'b00, 1, 8'b11_10_01_00, 0, "mid_clear_rot");
        applyStimulus(1, 16'h5678, 2'b01, 0, 8'h00, 0, "mid_push0");
        applyStimulus(1, 16'h9ABC, 2'b01, 0, 8'h00, 0, "mid_push1");
        in_valid = 1'b0;
        #1;
        arst = 1'b1;
        #1;
        checkResetState("mid");
        modelReset();
        #1;
        arst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("mid_after");
        applyStimulus(1, 16'h1234, 2'b01, 0, 8'h00, 1, "mid_rot");
        checkVal("mid_rot_word", 32'(out_data), 32'h1234);
        applyStimulus(1, 16'h1234, 2'b00, 0, 8'h00, 1, "mid_id");
        checkVal("mid_id_word", 32'(out_data), 32'h1234);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom),
                          ($urandom_range(0, 7) == 0), 8'($urandom),
                          1'($urandom_range(0, 1)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
